// File: rtl/music_pkg.sv
// Shared types, note/tempo tables and the score ROM for the polyphonic sequencer.
package music_pkg;

   typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_e;

   typedef enum logic [1:0] {
      TEMPO_NORMAL     = 2'b00,
      TEMPO_HALF       = 2'b01,
      TEMPO_DOUBLE     = 2'b10,
      TEMPO_NORMAL_ALT = 2'b11
   } tempo_e;

   localparam logic [3:0] NOTE_C4 = 4'd0;
   localparam logic [3:0] NOTE_D4 = 4'd1;
   localparam logic [3:0] NOTE_E4 = 4'd2;
   localparam logic [3:0] NOTE_F4 = 4'd3;
   localparam logic [3:0] NOTE_G4 = 4'd4;
   localparam logic [3:0] NOTE_A4 = 4'd5;
   localparam logic [3:0] NOTE_B4 = 4'd6;
   localparam logic [3:0] NOTE_C5 = 4'd7;
   localparam logic [3:0] NOTE_D5 = 4'd8;
   localparam logic [3:0] NOTE_E5 = 4'd9;
   localparam logic [3:0] NOTE_F5 = 4'd10;
   localparam logic [3:0] NOTE_G5 = 4'd11;
   localparam logic [3:0] REST    = 4'hF;

   // 25 MHz system clock expressed in millihertz
   localparam logic [63:0] CLK_MHZ = 64'd25_000_000_000;

   function automatic logic [19:0] note_freq_mhz(input logic [3:0] note);
      logic [19:0] f;
      case (note)
         NOTE_C4: f = 20'd261626;
         NOTE_D4: f = 20'd293665;
         NOTE_E4: f = 20'd329628;
         NOTE_F4: f = 20'd349228;
         NOTE_G4: f = 20'd391995;
         NOTE_A4: f = 20'd440000;
         NOTE_B4: f = 20'd493883;
         NOTE_C5: f = 20'd523251;
         NOTE_D5: f = 20'd587330;
         NOTE_E5: f = 20'd659255;
         NOTE_F5: f = 20'd698456;
         NOTE_G5: f = 20'd783991;
         default: f = 20'd0;
      endcase
      return f;
   endfunction

   function automatic logic is_pitch(input logic [3:0] note);
      return note < 4'd12;
   endfunction

   // Per-tick phase step: 2^EXT * f / (f_clk / 2^sb), rounded to nearest
   function automatic logic [63:0] note_inc(input logic [3:0] note, input int unsigned sb,
                                            input int unsigned eb);
      logic [63:0] f;
      f = 64'(note_freq_mhz(note));
      return ((f << (2 * sb + eb)) + (CLK_MHZ >> 1)) / CLK_MHZ;
   endfunction

   function automatic int unsigned len16(input logic [3:0] code);
      return (code == 4'd0) ? 32'd16 : 32'(code);
   endfunction

   function automatic int unsigned note_ticks(input logic [3:0] len_code, input tempo_e tempo,
                                              input int unsigned base);
      int unsigned t;
      case (tempo)
         TEMPO_HALF:   t = base << 1;
         TEMPO_DOUBLE: t = base >> 1;
         default:      t = base;
      endcase
      return len16(len_code) * t;
   endfunction

   // Row record {note0, note1, note2, note3, len}
   function automatic logic [19:0] score_row(input int unsigned idx);
      logic [19:0] rec;
      case (idx)
         0:       rec = {NOTE_C4, REST,    REST,    REST,    4'd1};
         1:       rec = {REST,    REST,    NOTE_E4, NOTE_G4, 4'd1};
         2:       rec = {NOTE_E4, NOTE_G4, NOTE_C5, REST,    4'd1};
         3:       rec = {4'hD,    NOTE_G5, NOTE_C4, NOTE_E4, 4'd1};
         4:       rec = {NOTE_G4, NOTE_E4, NOTE_C4, REST,    4'd2};
         5:       rec = {NOTE_A4, NOTE_F4, NOTE_D4, REST,    4'd2};
         6:       rec = {NOTE_B4, NOTE_G4, NOTE_D4, NOTE_G5, 4'd4};
         7:       rec = {NOTE_C5, NOTE_G4, NOTE_E4, NOTE_C4, 4'd0};
         default: rec = {4'(idx % 12), 4'((idx + 4) % 12), 4'((idx + 7) % 12), REST, 4'(idx % 4)};
      endcase
      return rec;
   endfunction

   // Field 0..3 selects a voice note, field 4 the length code
   function automatic logic [3:0] score_field(input int unsigned idx, input int unsigned fld);
      return 4'(score_row(idx) >> (4 * (4 - fld)));
   endfunction

endpackage

// File: rtl/music_voice.sv
// One sawtooth voice: phase accumulator with rest/gap gating and sample extraction.
module music_voice
   import music_pkg::*;
#(
   parameter int unsigned SAMPLE_BITS = 7,
   parameter int unsigned EXTRA_BITS  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_clr,
   input  logic                   i_en,
   input  logic                   i_gap,
   input  logic [3:0]             i_note,
   output logic [SAMPLE_BITS-1:0] o_sample_c
);

   localparam int unsigned EXT = SAMPLE_BITS + EXTRA_BITS;

   logic [EXT-1:0] r_phase;
   logic [EXT-1:0] w_inc;
   logic           w_active;

   assign w_inc    = EXT'(note_inc(i_note, SAMPLE_BITS, EXTRA_BITS));
   assign w_active = is_pitch(i_note) && !i_gap;

   // Phase carries over between notes; only a fresh start clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase <= '0;
      end else if (i_clr) begin
         r_phase <= '0;
      end else if (i_en && w_active) begin
         r_phase <= r_phase + w_inc;
      end
   end

   assign o_sample_c = w_active ? r_phase[EXT-1 -: SAMPLE_BITS] : '0;

endmodule

// File: rtl/music_sequencer_poly.sv
// Polyphonic score player: FSM, tick/note counters, score lookup, voice mixer and PWM output.
module music_sequencer_poly
   import music_pkg::*;
#(
   parameter int unsigned SAMPLE_BITS     = 7,
   parameter int unsigned EXTRA_BITS      = 8,
   parameter int unsigned VOICES          = 2,
   parameter int unsigned SCORE_LEN       = 64,
   parameter int unsigned BASE_16TH_TICKS = 24414,
   parameter int unsigned GAP_TICKS       = 512
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic                         stop_i,
   input  logic                         loop_i,
   input  logic [1:0]                   tempo_i,
   output logic                         pwm_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [$clog2(SCORE_LEN)-1:0] row_o
);

   localparam int unsigned ROW_W = $clog2(SCORE_LEN);
   localparam int unsigned DUR_W = $clog2(BASE_16TH_TICKS * 32 + 1);
   localparam int unsigned VSH   = $clog2(VOICES);
   localparam int unsigned MIX_W = SAMPLE_BITS + VSH;
   localparam logic [SAMPLE_BITS-1:0] POS_MAX  = '1;
   localparam logic [ROW_W-1:0]       ROW_LAST = ROW_W'(SCORE_LEN - 1);
   localparam logic [DUR_W-1:0]       GAP_D    = DUR_W'(GAP_TICKS);

   state_e                 r_state, w_state_nxt;
   logic [SAMPLE_BITS-1:0] r_pos, r_mix;
   logic [ROW_W-1:0]       r_row, w_load_row;
   logic [DUR_W-1:0]       r_cnt, r_dur, w_dur_load;
   logic                   r_pwm, r_busy, r_done;
   logic                   w_tick, w_note_end, w_last, w_gap, w_run;
   logic                   w_load, w_clr, w_done;
   logic [SAMPLE_BITS-1:0] w_samp [VOICES];
   logic [MIX_W-1:0]       w_sum;

   assign w_tick     = (r_pos == POS_MAX);
   assign w_note_end = (r_cnt == r_dur - DUR_W'(1));
   assign w_last     = (r_row == ROW_LAST);
   assign w_gap      = (GAP_TICKS != 0) && (r_dur > GAP_D) && (r_cnt >= r_dur - GAP_D);
   assign w_run      = (r_state == ST_PLAY) && w_tick && !stop_i;
   assign w_dur_load = DUR_W'(note_ticks(score_field(32'(w_load_row), 4), tempo_e'(tempo_i),
                                         BASE_16TH_TICKS));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state plus row-load / clear / done strobes; stop outranks start
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_clr       = 1'b0;
      w_done      = 1'b0;
      w_load_row  = '0;
      case (r_state)
         ST_IDLE: begin
            if (start_i && !stop_i) begin
               w_state_nxt = ST_PLAY;
               w_load      = 1'b1;
               w_clr       = 1'b1;
            end
         end
         ST_PLAY: begin
            if (stop_i) begin
               w_state_nxt = ST_IDLE;
            end else if (w_tick && w_note_end) begin
               if (!w_last) begin
                  w_load     = 1'b1;
                  w_load_row = r_row + ROW_W'(1);
               end else if (loop_i) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_done      = 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pos  <= '0;
         r_row  <= '0;
         r_cnt  <= '0;
         r_dur  <= '0;
         r_mix  <= '0;
         r_pwm  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_pos  <= r_pos + SAMPLE_BITS'(1);
         r_pwm  <= (r_pos < r_mix);
         r_busy <= (w_state_nxt == ST_PLAY);
         r_done <= w_done;
         if (w_state_nxt == ST_IDLE) begin
            r_row <= '0;
            r_cnt <= '0;
            r_mix <= '0;
         end else begin
            if (w_load) begin
               r_row <= w_load_row;
               r_cnt <= '0;
               r_dur <= w_dur_load;
            end else if (w_tick) begin
               r_cnt <= r_cnt + DUR_W'(1);
            end
            if (w_run) r_mix <= SAMPLE_BITS'(w_sum >> VSH);
         end
      end
   end

   for (genvar v = 0; v < VOICES; v++) begin : g_voice
      music_voice #(
         .SAMPLE_BITS(SAMPLE_BITS),
         .EXTRA_BITS (EXTRA_BITS)
      ) u_voice (
         .clk       (clk),
         .rst       (rst),
         .i_clr     (w_clr),
         .i_en      (w_run),
         .i_gap     (w_gap),
         .i_note    (score_field(32'(r_row), v)),
         .o_sample_c(w_samp[v])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int v = 0; v < VOICES; v++) w_sum = w_sum + MIX_W'(w_samp[v]);
   end

   assign pwm_o  = r_pwm;
   assign busy_o = r_busy;
   assign done_o = r_done;
   assign row_o  = r_row;

endmodule

// File: tb/tb_music_sequencer_poly.sv
// Self-checking bench for music_sequencer_poly: directed tables/sequences plus random control vs a tick-level model.
module tb_music_sequencer_poly;

   localparam int SB   = 3;
   localparam int EB   = 20;
   localparam int EXT  = SB + EB;
   localparam int V    = 2;
   localparam int SL   = 4;
   localparam int BASE = 4;
   localparam int GAP  = 1;

   logic       clk = 1'b0;
   logic       rst, start_i, stop_i, loop_i;
   logic [1:0] tempo_i;
   logic       pwm_o, busy_o, done_o;
   logic [1:0] row_o;

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   music_sequencer_poly #(
      .SAMPLE_BITS(SB), .EXTRA_BITS(EB), .VOICES(V), .SCORE_LEN(SL),
      .BASE_16TH_TICKS(BASE), .GAP_TICKS(GAP)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .loop_i(loop_i),
      .tempo_i(tempo_i), .pwm_o(pwm_o), .busy_o(busy_o), .done_o(done_o), .row_o(row_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- reference model (score rows 0..3 as written in the score) ----------------
   int notes_tab [SL][V] = '{'{0, 15}, '{15, 15}, '{2, 4}, '{13, 11}};
   int lens_tab  [SL]    = '{1, 1, 1, 1};

   function automatic longint unsigned inc_of(input int note);
      longint unsigned f;
      case (note)
         0: f = 261626;  1: f = 293665;  2: f = 329628;  3: f = 349228;
         4: f = 391995;  5: f = 440000;  6: f = 493883;  7: f = 523251;
         8: f = 587330;  9: f = 659255; 10: f = 698456; 11: f = 783991;
         default: f = 0;
      endcase
      return ((f << (2 * SB + EB)) + 64'd12500000000) / 64'd25000000000;
   endfunction

   function automatic int unsigned row_ticks(input int row, input logic [1:0] tempo);
      int unsigned len16, t;
      len16 = (lens_tab[row] == 0) ? 16 : lens_tab[row];
      t = (tempo == 2'b01) ? BASE * 2 : (tempo == 2'b10) ? BASE / 2 : BASE;
      return len16 * t;
   endfunction

   int unsigned     m_pos, m_mix, m_row, m_cnt, m_dur;
   bit              m_play, m_pwm, m_done, m_valid;
   longint unsigned m_ph [V];

   always @(posedge clk) begin
      bit          tick, gap;
      int unsigned sum;
      tick = (m_pos == (1 << SB) - 1);
      if (rst) begin
         m_pos = 0; m_mix = 0; m_row = 0; m_cnt = 0; m_dur = 0;
         m_play = 0; m_pwm = 0; m_done = 0; m_valid = 1;
         for (int v = 0; v < V; v++) m_ph[v] = 0;
      end else begin
         m_pwm  = (m_pos < m_mix);
         m_pos  = (m_pos + 1) % (1 << SB);
         m_done = 0;
         if (!m_play) begin
            m_mix = 0;
            if (start_i && !stop_i) begin
               m_play = 1; m_row = 0; m_cnt = 0; m_dur = row_ticks(0, tempo_i);
               for (int v = 0; v < V; v++) m_ph[v] = 0;
            end
         end else if (stop_i) begin
            m_play = 0; m_row = 0; m_cnt = 0; m_mix = 0;
         end else if (tick) begin
            sum = 0;
            gap = (GAP > 0) && (m_dur > GAP) && (m_cnt >= m_dur - GAP);
            for (int v = 0; v < V; v++) begin
               if (notes_tab[m_row][v] < 12 && !gap) begin
                  sum += int'(m_ph[v] >> EB);
                  m_ph[v] = (m_ph[v] + inc_of(notes_tab[m_row][v])) % (64'd1 << EXT);
               end
            end
            m_mix = sum / V;
            if (m_cnt == m_dur - 1) begin
               m_cnt = 0;
               if (m_row == SL - 1) begin
                  if (loop_i) begin
                     m_row = 0; m_dur = row_ticks(0, tempo_i);
                  end else begin
                     m_play = 0; m_row = 0; m_done = 1; m_mix = 0;
                  end
               end else begin
                  m_row++;
                  m_dur = row_ticks(int'(m_row), tempo_i);
               end
            end else begin
               m_cnt++;
            end
         end
      end
   end

   // Continuous output/phase comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         check("outputs{pwm,busy,done,row}", {pwm_o, busy_o, done_o, row_o},
               {m_pwm, m_play, m_done, 2'(m_row)});
         check("phases{v0,v1}", {dut.g_voice[0].u_voice.r_phase, dut.g_voice[1].u_voice.r_phase},
               {23'(m_ph[0]), 23'(m_ph[1])});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start();
      start_i = 1'b1; @(negedge clk); start_i = 1'b0;
   endtask

   task automatic pulse_stop();
      stop_i = 1'b1; @(negedge clk); stop_i = 1'b0;
   endtask

   task automatic wait_row_change(output int unsigned at);
      logic [1:0]  prev;
      int unsigned n;
      prev = row_o;
      n = 0;
      do begin @(negedge clk); n++; end while (row_o == prev && n < 2000);
      at = cyc;
      if (row_o == prev) check("row_change_timeout", 0, 1);
   endtask

   typedef struct {
      logic [1:0]  tempo;
      int unsigned clocks;
   } tempo_vec_t;

   tempo_vec_t vecs [4];

   initial begin
      int unsigned a1, a2, a3, bad, n, dones, lows, wraps;
      logic        prev_busy;
      logic [1:0]  prev_row;

      vecs[0] = '{2'b00, 32};
      vecs[1] = '{2'b01, 64};
      vecs[2] = '{2'b10, 16};
      vecs[3] = '{2'b11, 32};

      rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; tempo_i = 2'b00;
      repeat (5) @(negedge clk);
      check("reset_pwm", pwm_o, 0);
      check("reset_busy", busy_o, 0);
      check("reset_row", row_o, 0);
      check("reset_done", done_o, 0);
      rst = 1'b0;

      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (pwm_o || busy_o || row_o != 0) bad++;
      end
      check("idle_no_start_activity", bad, 0);

      // Row period per tempo, measured between two mid-score row changes
      loop_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tempo_i = vecs[i].tempo;
         pulse_start();
         wait_row_change(a1);
         wait_row_change(a2);
         wait_row_change(a3);
         check("tempo_row_period", a3 - a2, vecs[i].clocks);
         check("tempo_busy", busy_o, 1);
         pulse_stop();
         repeat (3) @(negedge clk);
      end

      // Single-voice C4 phase over row 0 and silence over the all-REST row
      tempo_i = 2'b00;
      pulse_start();
      wait_row_change(a1);
      check("c4_phase_row0", dut.g_voice[0].u_voice.r_phase, 3 * inc_of(0));
      check("rest_phase_row0", dut.g_voice[1].u_voice.r_phase, 0);
      bad = 0; n = 0;
      while (row_o == 2'd1 && n < 200) begin
         if (pwm_o) bad++;
         @(negedge clk); n++;
      end
      check("rest_row_pwm_silent", bad, 0);
      pulse_stop();
      repeat (3) @(negedge clk);

      // One-shot end
      loop_i = 1'b0;
      pulse_start();
      n = 0; prev_busy = busy_o;
      while (!done_o && n < 1000) begin
         prev_busy = busy_o;
         @(negedge clk); n++;
      end
      check("oneshot_done_seen", done_o, 1);
      check("oneshot_busy_before", prev_busy, 1);
      check("oneshot_busy_fall", busy_o, 0);
      check("oneshot_row_zero", row_o, 0);
      @(negedge clk);
      check("oneshot_done_one_cycle", done_o, 0);
      repeat (3) @(negedge clk);

      // Looping: 3 full passes, never idle, never done
      loop_i = 1'b1;
      pulse_start();
      dones = 0; lows = 0; wraps = 0; prev_row = row_o;
      repeat (3 * SL * 32 + 64) begin
         @(negedge clk);
         if (done_o) dones++;
         if (!busy_o) lows++;
         if (prev_row == 2'd3 && row_o == 2'd0) wraps++;
         prev_row = row_o;
      end
      check("loop_no_done", dones, 0);
      check("loop_no_idle", lows, 0);
      check("loop_wraps_ge3", wraps >= 3, 1);

      // Simultaneous stop+start mid-row
      repeat (13) @(negedge clk);
      start_i = 1'b1; stop_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; stop_i = 1'b0;
      check("stop_start_busy", busy_o, 0);
      check("stop_start_row", row_o, 0);
      @(negedge clk);
      check("stop_start_stays_idle", busy_o, 0);

      // Reset mid-note
      pulse_start();
      repeat (45) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", busy_o, 0);
      check("midrst_row", row_o, 0);
      check("midrst_pwm", pwm_o, 0);
      check("midrst_done", done_o, 0);
      check("midrst_phase0", dut.g_voice[0].u_voice.r_phase, 0);
      check("midrst_mix", dut.r_mix, 0);
      repeat (10) @(negedge clk);
      check("midrst_no_pending_start", busy_o, 0);

      // Random control traffic, judged by the model
      for (int c = 0; c < 3000; c++) begin
         start_i = ($urandom % 40) == 0;
         stop_i  = ($urandom % 300) == 0;
         rst     = ($urandom % 1000) == 0;
         if (c % 200 == 0) loop_i = 1'($urandom % 2);
         if (c % 97 == 0) tempo_i = 2'($urandom % 4);
         @(negedge clk);
      end
      start_i = 1'b0; stop_i = 1'b0; rst = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
